// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: BCD_SIGN_EN (two's-complement input with sign output).
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit adjust: any digit >= 5 gets +3 before the left shift
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  // Ceiling log2, valid for value >= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter must hold BIN_W itself, hence BIN_W+1 codes
  function automatic int cnt_width(input int bin_w);
    return clog2(bin_w + 1);
  endfunction

  // Packed BCD result width
  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction used by the double-dabble shifter.
// Optional feature macro: BCD_SIGN_EN (not used in this file).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  // Add 3 to any digit of 5 or more so the following shift carries correctly
  always_comb begin
    o_dig = i_dig;
    if (i_dig >= ADJ_THRESH) begin
      o_dig = i_dig + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake and sticky overflow. One conversion takes BIN_W+2 cycles.
// Optional feature macro: BCD_SIGN_EN -- when defined bin_in is two's complement,
// the magnitude is converted and sign_out reports the sign; when undefined
// sign_out is tied to 0.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  sign_out
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_acc;
  logic [BIN_W-1:0]   r_mag;
  logic               r_ovf_acc;

  logic               w_accept;
  logic [BCD_W-1:0]   w_adj;
  logic [3:0]         w_top_adj;
  logic               w_ovf_step;
  logic [BIN_W-1:0]   w_load_mag;

  assign w_accept = (r_state == IDLE) && start;

  // All digits are corrected in parallel from the current accumulator
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_acc[4*g +: 4]),
      .o_dig (w_adj[4*g +: 4])
    );
  end

  // A 1 leaving the top digit, or a top digit beyond 9, means the value
  // does not fit in DIGITS digits; only the low digits survive.
  assign w_top_adj  = w_adj[BCD_W-1 -: 4];
  assign w_ovf_step = w_top_adj[3] | (w_top_adj > DIGIT_MAX);

`ifdef BCD_SIGN_EN
  logic w_neg;
  logic r_sign;

  assign w_neg = bin_in[BIN_W-1];
  // Magnitude is kept as BIN_W unsigned bits so the most negative value converts
  assign w_load_mag = w_neg ? (-bin_in) : bin_in;

  // Latch the operand sign on accept, publish it with the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign   <= 1'b0;
      sign_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign <= w_neg;
      end
      if (r_state == DONE) begin
        sign_out <= r_sign;
      end
    end
  end
`else
  assign w_load_mag = bin_in;
  assign sign_out   = 1'b0;
`endif

  // Control FSM, shift counter, sticky overflow and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= SHIFT;
            r_cnt     <= CNT_LOAD;
            r_ovf_acc <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          r_cnt     <= r_cnt - CNT_ONE;
          r_ovf_acc <= r_ovf_acc | w_ovf_step;
          if (r_cnt == CNT_ONE) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          bcd_out <= r_acc;
          ovf     <= r_ovf_acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: load operand on accept, otherwise adjust-then-shift while in SHIFT
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc <= '0;
      r_mag <= w_load_mag;
    end else if (r_state == SHIFT) begin
      {r_acc, r_mag} <= {w_adj[BCD_W-2:0], r_mag, 1'b0};
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: a 5-digit and a 4-digit instance,
// BIN_W=16. Build with BCD_SIGN_EN defined to exercise the signed variant.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start5, start4;
  logic [15:0] bin5, bin4;
  logic        busy5, done5, ovf5, sign5;
  logic        busy4, done4, ovf4, sign4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .bin_in(bin5),
    .busy(busy5), .done(done5), .bcd_out(bcd5), .ovf(ovf5), .sign_out(sign5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .ovf(ovf4), .sign_out(sign4)
  );

`ifdef BCD_SIGN_EN
  localparam logic [19:0] EXP_FFFF     = 20'h00001;  // -1
  localparam logic        EXP_FFFF_SGN = 1'b1;
  localparam logic        EXP_8000_SGN = 1'b1;
`else
  localparam logic [19:0] EXP_FFFF     = 20'h65535;
  localparam logic        EXP_FFFF_SGN = 1'b0;
  localparam logic        EXP_8000_SGN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one start pulse from IDLE and waits for done. lat counts edges
  // after the accepting edge until done is first seen high (-1 on timeout).
  task automatic run_conv(input bit d4, input logic [15:0] val, output int lat,
                          output logic [19:0] bcd, output logic ov, output logic sg);
    logic [19:0] prev;
    prev = d4 ? {4'h0, bcd4} : bcd5;
    if (d4) begin start4 = 1'b1; bin4 = val; end
    else    begin start5 = 1'b1; bin5 = val; end
    @(posedge clk); #1;
    start4 = 1'b0;
    start5 = 1'b0;
    chk("busy_after_start", 32'(d4 ? busy4 : busy5), 32'(1));
    chk("hold_at_start", 32'(d4 ? {4'h0, bcd4} : bcd5), 32'(prev));
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (d4 ? done4 : done5) lat = c;
    end
    bcd = d4 ? {4'h0, bcd4} : bcd5;
    ov  = d4 ? ovf4 : ovf5;
    sg  = d4 ? sign4 : sign5;
  endtask

  initial begin
    int          lat;
    int          ndone;
    bit          busy_ok;
    logic [19:0] b;
    logic        o, s;

    reset = 1'b1;
    start5 = 1'b0; start4 = 1'b0;
    bin5 = '0; bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy5), 32'(0));
    chk("rst_done", 32'(done5), 32'(0));
    chk("rst_bcd",  32'(bcd5),  32'(0));
    chk("rst_ovf",  32'(ovf5),  32'(0));
    chk("rst_sign", 32'(sign5), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic conversion and latency: done first seen after edge k+BIN_W+1
    run_conv(1'b0, 16'd1234, lat, b, o, s);
    chk("t1_latency", 32'(lat), 32'(17));
    chk("t1_bcd",  32'(b), 32'h01234);
    chk("t1_ovf",  32'(o), 32'(0));
    chk("t1_sign", 32'(s), 32'(0));
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(done5), 32'(0));

    // Full-scale, then zero started in the cycle right after done
    run_conv(1'b0, 16'hFFFF, lat, b, o, s);
    chk("t2_ffff_bcd",  32'(b), 32'(EXP_FFFF));
    chk("t2_ffff_ovf",  32'(o), 32'(0));
    chk("t2_ffff_sign", 32'(s), 32'(EXP_FFFF_SGN));
    run_conv(1'b0, 16'd0, lat, b, o, s);
    chk("t2_b2b_latency", 32'(lat), 32'(17));
    chk("t2_zero_bcd", 32'(b), 32'h00000);
    chk("t2_zero_ovf", 32'(o), 32'(0));

    // 4-digit instance: fits, then overflows (low digits kept)
    run_conv(1'b1, 16'd9999, lat, b, o, s);
    chk("t3_9999_bcd", 32'(b), 32'h09999);
    chk("t3_9999_ovf", 32'(o), 32'(0));
    run_conv(1'b1, 16'd12345, lat, b, o, s);
    chk("t3_12345_latency", 32'(lat), 32'(17));
    chk("t3_12345_bcd", 32'(b), 32'h02345);
    chk("t3_12345_ovf", 32'(o), 32'(1));

    // Second start during SHIFT is ignored and not queued
    start5 = 1'b1; bin5 = 16'd5678;
    @(posedge clk); #1;
    start5 = 1'b0;
    busy_ok = 1'b1; ndone = 0; lat = -1; b = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start5 = (c == 5);
      if (c == 5) bin5 = 16'd4321;
      if (done5) begin
        ndone++;
        if (lat < 0) begin lat = c; b = bcd5; end
      end else if (lat < 0 && !busy5) begin
        busy_ok = 1'b0;
      end
    end
    chk("t4_latency",   32'(lat), 32'(17));
    chk("t4_done_cnt",  32'(ndone), 32'(1));
    chk("t4_busy_held", 32'(busy_ok), 32'(1));
    chk("t4_bcd",       32'(b), 32'h05678);
    chk("t4_busy_end",  32'(busy5), 32'(0));
    chk("t4_final_bcd", 32'(bcd5), 32'h05678);

    // Asynchronous reset mid-SHIFT aborts the conversion
    start5 = 1'b1; bin5 = 16'd4321;
    @(posedge clk); #1;
    start5 = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy5), 32'(0));
    chk("t5_done", 32'(done5), 32'(0));
    chk("t5_bcd",  32'(bcd5),  32'(0));
    chk("t5_ovf4", 32'(ovf4),  32'(0));
    chk("t5_bcd4", 32'(bcd4),  32'(0));
    #3 reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done5) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'(0));
    run_conv(1'b0, 16'd4321, lat, b, o, s);
    chk("t5_after_latency", 32'(lat), 32'(17));
    chk("t5_after_bcd", 32'(b), 32'h04321);

    // Top bit set: signed variant reports -32768, unsigned reports 32768
    run_conv(1'b0, 16'h8000, lat, b, o, s);
    chk("t6_8000_bcd",  32'(b), 32'h32768);
    chk("t6_8000_sign", 32'(s), 32'(EXP_8000_SGN));
    chk("t6_8000_ovf",  32'(o), 32'(0));
`ifdef BCD_SIGN_EN
    run_conv(1'b0, 16'hFFD6, lat, b, o, s);  // -42
    chk("t6_m42_bcd",  32'(b), 32'h00042);
    chk("t6_m42_sign", 32'(s), 32'(1));
    run_conv(1'b0, 16'd42, lat, b, o, s);
    chk("t6_p42_bcd",  32'(b), 32'h00042);
    chk("t6_p42_sign", 32'(s), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
